// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : single-entry execute pipeline stage.
//
// Holds one instruction between decode/register-read and writeback.  The held
// opcode and operands drive an external combinational 32-bit ALU.  The ALU
// result and flags go downstream under a valid/ready handshake.  The stage
// also owns the architectural NZCV register, evaluates condition codes when an
// instruction is accepted, and forwards the departing result into the operands
// of an instruction entering in the same cycle.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   flush               discard the held instruction
//   in_valid/in_ready   upstream handshake
//   in_op, in_a, in_b   opcode and register-file / immediate operands
//   in_rs1, in_rs2      source indices used for forwarding
//   in_b_is_reg         b comes from rs2, so it may be forwarded
//   in_rd, in_we        destination index and write enable
//   in_set_flags        instruction updates NZCV
//   in_cond             condition code
//   alu_op/a/b          held opcode and operands to the ALU
//   alu_y, alu_nzcv     ALU result and {N,Z,C,V}
//   out_valid/out_ready downstream handshake
//   out_y, out_nzcv     ALU result and flags passed through
//   out_rd, out_we      held destination, write enable gated by condition
//   flags               architectural NZCV register
// ---------------------------------------------------------------------------
module ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_W  = 4,
   parameter int FWD_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [REG_W-1:0] in_rs1,
   input  logic [REG_W-1:0] in_rs2,
   input  logic             in_b_is_reg,
   input  logic [REG_W-1:0] in_rd,
   input  logic             in_we,
   input  logic             in_set_flags,
   input  logic [3:0]       in_cond,
   output logic [7:0]       alu_op,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   input  logic [XLEN-1:0]  alu_y,
   input  logic [3:0]       alu_nzcv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_y,
   output logic [3:0]       out_nzcv,
   output logic [REG_W-1:0] out_rd,
   output logic             out_we,
   output logic [3:0]       flags
);

   // Condition evaluation against an {N,Z,C,V} vector; codes 9..15 never pass.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'd0:    return 1'b1;
         4'd1:    return z;
         4'd2:    return !z;
         4'd3:    return c;
         4'd4:    return !c;
         4'd5:    return n;
         4'd6:    return !n;
         4'd7:    return v;
         4'd8:    return !v;
         default: return 1'b0;
      endcase
   endfunction

   logic             vld_p1;
   logic [7:0]       op_p1;
   logic [XLEN-1:0]  a_p1;
   logic [XLEN-1:0]  b_p1;
   logic [REG_W-1:0] rd_p1;
   logic             we_p1;
   logic             sf_p1;
   logic             cp_p1;
   logic [3:0]       flags_q;

   logic             accept;
   logic             depart;
   logic             flag_upd;
   logic             dep_wr;
   logic [3:0]       eff_flags;
   logic             fwd_a;
   logic             fwd_b;
   logic [XLEN-1:0]  a_p0;
   logic [XLEN-1:0]  b_p0;
   logic             cp_p0;

   // ---- stage p0: accept, condition evaluation and operand forwarding ----
   assign in_ready  = !flush && (!vld_p1 || out_ready);
   assign accept    = in_valid && in_ready;
   assign depart    = vld_p1 && out_ready && !flush;
   assign flag_upd  = depart && sf_p1 && cp_p1;
   assign dep_wr    = depart && we_p1 && cp_p1;

   // The entering instruction sees the flags the departing one is writing.
   assign eff_flags = ((FWD_EN != 0) && flag_upd) ? alu_nzcv : flags_q;
   assign cp_p0     = cond_eval(in_cond, eff_flags);

   // r0 is never forwarded; dep_wr already implies a departure this cycle.
   assign fwd_a = (FWD_EN != 0) && dep_wr && (rd_p1 == in_rs1) && (in_rs1 != '0);
   assign fwd_b = (FWD_EN != 0) && dep_wr && in_b_is_reg &&
                  (rd_p1 == in_rs2) && (in_rs2 != '0);
   assign a_p0  = fwd_a ? alu_y : in_a;
   assign b_p0  = fwd_b ? alu_y : in_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         op_p1   <= '0;
         a_p1    <= '0;
         b_p1    <= '0;
         rd_p1   <= '0;
         we_p1   <= 1'b0;
         sf_p1   <= 1'b0;
         cp_p1   <= 1'b0;
         flags_q <= '0;
      end else begin
         if (flag_upd)
            flags_q <= alu_nzcv;
         if (accept) begin
            vld_p1 <= 1'b1;
            op_p1  <= in_op;
            a_p1   <= a_p0;
            b_p1   <= b_p0;
            rd_p1  <= in_rd;
            we_p1  <= in_we;
            sf_p1  <= in_set_flags;
            cp_p1  <= cp_p0;
         end else if (depart || flush) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   // ---- stage p1: held instruction drives the ALU and the output port ----
   assign alu_op    = op_p1;
   assign alu_a     = a_p1;
   assign alu_b     = b_p1;
   assign out_valid = vld_p1;
   assign out_y     = alu_y;
   assign out_nzcv  = alu_nzcv;
   assign out_rd    = rd_p1;
   assign out_we    = we_p1 && cp_p1;
   assign flags     = flags_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_b_is_reg, in_we, in_set_flags, out_ready;
   logic [7:0]  in_op;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_rs1, in_rs2, in_rd, in_cond;

   logic        in_ready0, out_valid0, out_we0;
   logic [7:0]  alu_op0;
   logic [31:0] alu_a0, alu_b0, alu_y0, out_y0;
   logic [3:0]  alu_nzcv0, out_nzcv0, out_rd0, flags0;

   logic        in_ready1, out_valid1, out_we1;
   logic [7:0]  alu_op1;
   logic [31:0] alu_a1, alu_b1, alu_y1, out_y1;
   logic [3:0]  alu_nzcv1, out_nzcv1, out_rd1, flags1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Reference ALU: 0 MOV, 1 ADD, 2 SUB (C = borrow), 3 AND, 4 OR, 5 XOR, else pass a.
   function automatic logic [35:0] alu_f(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] y;
      logic        c, v;
      s = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         8'd0: y = b;
         8'd1: begin
            s = {1'b0, a} + {1'b0, b};
            y = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         8'd2: begin
            y = a - b;
            c = (a < b);
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         8'd3: y = a & b;
         8'd4: y = a | b;
         8'd5: y = a ^ b;
         default: y = a;
      endcase
      return {y[31], (y == 32'd0), c, v, y};
   endfunction

   assign {alu_nzcv0, alu_y0} = alu_f(alu_op0, alu_a0, alu_b0);
   assign {alu_nzcv1, alu_y1} = alu_f(alu_op1, alu_a1, alu_b1);

   ex_stage #(.XLEN(32), .REG_W(4), .FWD_EN(1)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_b_is_reg(in_b_is_reg), .in_rd(in_rd), .in_we(in_we),
      .in_set_flags(in_set_flags), .in_cond(in_cond), .alu_op(alu_op0),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_y(alu_y0), .alu_nzcv(alu_nzcv0),
      .out_valid(out_valid0), .out_ready(out_ready), .out_y(out_y0),
      .out_nzcv(out_nzcv0), .out_rd(out_rd0), .out_we(out_we0), .flags(flags0));

   ex_stage #(.XLEN(32), .REG_W(4), .FWD_EN(0)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_b_is_reg(in_b_is_reg), .in_rd(in_rd), .in_we(in_we),
      .in_set_flags(in_set_flags), .in_cond(in_cond), .alu_op(alu_op1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_y(alu_y1), .alu_nzcv(alu_nzcv1),
      .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1),
      .out_nzcv(out_nzcv1), .out_rd(out_rd1), .out_we(out_we1), .flags(flags1));

   // Architectural reference: instructions execute in program order against a
   // register file and NZCV; the stage with forwarding must match it exactly.
   logic [31:0] arch_rf [16];
   logic [3:0]  arch_flags;
   bit          m_on = 1'b0;
   bit          m_vld;
   logic [7:0]  m_op;
   logic [31:0] m_a, m_b, m_y;
   logic [3:0]  m_nzcv, m_rd;
   bit          m_we, m_upd;

   function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
      case (cond)
         4'd0: return 1'b1;      // AL
         4'd1: return f[2];      // EQ
         4'd2: return !f[2];     // NE
         4'd3: return f[1];      // CS
         4'd4: return !f[1];     // CC
         4'd5: return f[3];      // MI
         4'd6: return !f[3];     // PL
         4'd7: return f[0];      // VS
         4'd8: return !f[0];     // VC
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_edge();
      bit          dep, acc, cp;
      logic [31:0] a, b;
      logic [35:0] r;
      if (rst) begin
         m_vld      = 1'b0;
         arch_flags = 4'd0;
         return;
      end
      dep = m_vld && out_ready && !flush;
      acc = in_valid && !flush && (!m_vld || out_ready);
      if (dep) begin
         if (m_we && m_rd != 4'd0) arch_rf[m_rd] = m_y;
         if (m_upd) arch_flags = m_nzcv;
      end
      if (acc) begin
         a  = arch_rf[in_rs1];
         b  = in_b_is_reg ? arch_rf[in_rs2] : in_b;
         cp = cond_ok(in_cond, arch_flags);
         r  = alu_f(in_op, a, b);
         m_vld  = 1'b1;
         m_op   = in_op;
         m_a    = a;
         m_b    = b;
         m_y    = r[31:0];
         m_nzcv = r[35:32];
         m_rd   = in_rd;
         m_we   = in_we && cp;
         m_upd  = in_set_flags && cp;
      end else if (dep || flush) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (m_on) model_edge();
      #1;
   endtask

   task automatic drv(input bit v, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] rs1, input logic [3:0] rs2,
                      input bit breg, input logic [3:0] rd, input bit we, input bit sf,
                      input logic [3:0] cond);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_rs1 = rs1; in_rs2 = rs2;
      in_b_is_reg = breg; in_rd = rd; in_we = we; in_set_flags = sf; in_cond = cond;
   endtask

   task automatic rand_drive();
      logic [3:0] rs1, rs2;
      bit         breg;
      logic [31:0] imm;
      rs1  = 4'($urandom_range(0, 3));
      rs2  = 4'($urandom_range(0, 3));
      breg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0: imm = 32'd0;
         1: imm = 32'hFFFF_FFFF;
         2: imm = 32'h8000_0000;
         default: imm = $urandom;
      endcase
      drv(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)), arch_rf[rs1],
          breg ? arch_rf[rs2] : imm, rs1, rs2, breg, 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_out_we",    32'(out_we0),    32'd0);
      chk("rst_alu_op",    32'(alu_op0),    32'd0);
      chk("rst_alu_a",     alu_a0,          32'd0);
      chk("rst_alu_b",     alu_b0,          32'd0);
      chk("rst_flags",     32'(flags0),     32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready0),  32'd1);

      // ADD 5+7 -> r3
      drv(1, 8'd1, 32'd5, 32'd7, 4'd1, 4'd2, 0, 4'd3, 1, 0, 4'd0);
      step();
      chk("add_valid", 32'(out_valid0), 32'd1);
      chk("add_y",     out_y0,          32'd12);
      chk("add_rd",    32'(out_rd0),    32'd3);
      chk("add_we",    32'(out_we0),    32'd1);
      chk("add_flags", 32'(flags0),     32'd0);

      // SUB 4-4 sets Z, then MOV cond=EQ accepted as SUB departs
      drv(1, 8'd2, 32'd4, 32'd4, 4'd1, 4'd2, 0, 4'd0, 0, 1, 4'd0);
      step();
      chk("sub_y", out_y0, 32'd0);
      drv(1, 8'd0, 32'd0, 32'd9, 4'd0, 4'd0, 0, 4'd5, 1, 0, 4'd1);
      step();
      chk("eq_flags",    32'(flags0),  32'b0100);
      chk("eq_we",       32'(out_we0), 32'd1);
      chk("eq_y",        out_y0,       32'd9);
      chk("eq_rd",       32'(out_rd0), 32'd5);
      chk("eq_nofwd_we", 32'(out_we1), 32'd0);

      // Same with cond=NE: fails, and its own set_flags must not take effect
      drv(1, 8'd2, 32'd4, 32'd4, 4'd1, 4'd2, 0, 4'd0, 0, 1, 4'd0);
      step();
      drv(1, 8'd0, 32'd0, 32'h8000_0000, 4'd0, 4'd0, 0, 4'd5, 1, 1, 4'd2);
      step();
      chk("ne_valid", 32'(out_valid0), 32'd1);
      chk("ne_we",    32'(out_we0),    32'd0);
      chk("ne_y",     out_y0,          32'h8000_0000);
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      step();
      chk("ne_flags", 32'(flags0),     32'b0100);
      chk("ne_drain", 32'(out_valid0), 32'd0);

      // Forwarding of both operands from r1 = 1+2
      drv(1, 8'd1, 32'd1, 32'd2, 4'd0, 4'd0, 0, 4'd1, 1, 0, 4'd0);
      step();
      drv(1, 8'd1, 32'd0, 32'd0, 4'd1, 4'd1, 1, 4'd2, 1, 0, 4'd0);
      step();
      chk("fwd_ab_y",   out_y0, 32'd6);
      chk("nofwd_ab_y", out_y1, 32'd0);
      drv(1, 8'd1, 32'd1, 32'd2, 4'd0, 4'd0, 0, 4'd1, 1, 0, 4'd0);
      step();
      drv(1, 8'd1, 32'd0, 32'd0, 4'd0, 4'd1, 1, 4'd2, 1, 0, 4'd0);
      step();
      chk("fwd_r0_y", out_y0, 32'd3);
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      step();

      // Stall: held ADD 10+20 for four cycles with upstream pushing
      drv(1, 8'd1, 32'd10, 32'd20, 4'd0, 4'd0, 0, 4'd4, 1, 0, 4'd0);
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         drv(1, 8'd3, 32'd99, 32'd99, 4'd0, 4'd0, 0, 4'd6, 1, 1, 4'd0);
         #1;
         chk("stall_in_ready", 32'(in_ready0),  32'd0);
         step();
         chk("stall_valid",    32'(out_valid0), 32'd1);
         chk("stall_y",        out_y0,          32'd30);
         chk("stall_alu_a",    alu_a0,          32'd10);
         chk("stall_rd",       32'(out_rd0),    32'd4);
         chk("stall_flags",    32'(flags0),     32'b0100);
      end
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready0), 32'd1);
      step();
      chk("release_single", 32'(out_valid0), 32'd0);

      // Flush a held flag-setting SUB 0-1
      rst = 1'b1;
      step();
      rst = 1'b0;
      drv(1, 8'd2, 32'd0, 32'd1, 4'd0, 4'd0, 0, 4'd1, 1, 1, 4'd0);
      step();
      chk("flush_held", 32'(out_valid0), 32'd1);
      drv(1, 8'd1, 32'd1, 32'd1, 4'd0, 4'd0, 0, 4'd2, 1, 1, 4'd0);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready0), 32'd0);
      step();
      flush = 1'b0;
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      chk("flush_valid", 32'(out_valid0), 32'd0);
      chk("flush_flags", 32'(flags0),     32'd0);
      step();
      chk("flush_noacc", 32'(out_valid0), 32'd0);

      // Reset mid-stall with flags = 1000
      drv(1, 8'd0, 32'd0, 32'h8000_0000, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd0);
      step();
      drv(1, 8'd1, 32'd3, 32'd4, 4'd0, 4'd0, 0, 4'd7, 1, 0, 4'd0);
      step();
      chk("n_flags", 32'(flags0), 32'b1000);
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      out_ready = 1'b0;
      step();
      chk("prerst_alu_a", alu_a0, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("midrst_flags", 32'(flags0),     32'd0);
      chk("midrst_valid", 32'(out_valid0), 32'd0);
      chk("midrst_alu_a", alu_a0,          32'd0);

      // Condition codes 9..15 never pass
      for (int c = 9; c < 16; c++) begin
         drv(1, 8'd1, 32'(c), 32'd1, 4'd0, 4'd0, 0, 4'd8, 1, 1, 4'(c));
         step();
         chk("never_valid", 32'(out_valid0), 32'd1);
         chk("never_we",    32'(out_we0),    32'd0);
         chk("never_y",     out_y0,          32'(c + 1));
      end
      drv(0, 8'd0, 32'd0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      step();
      chk("never_flags", 32'(flags0), 32'd0);

      // Randomized run against the architectural reference
      arch_rf[0] = 32'd0;
      for (int r = 1; r < 16; r++) arch_rf[r] = $urandom;
      m_on = 1'b1;
      rst  = 1'b1;
      step();
      rst = 1'b0;
      for (int n = 0; n < 600; n++) begin
         rand_drive();
         step();
         chk("rnd_valid", 32'(out_valid0), 32'(m_vld));
         chk("rnd_flags", 32'(flags0),     32'(arch_flags));
         if (m_vld) begin
            chk("rnd_alu_op", 32'(alu_op0),   32'(m_op));
            chk("rnd_alu_a",  alu_a0,         m_a);
            chk("rnd_alu_b",  alu_b0,         m_b);
            chk("rnd_y",      out_y0,         m_y);
            chk("rnd_nzcv",   32'(out_nzcv0), 32'(m_nzcv));
            chk("rnd_rd",     32'(out_rd0),   32'(m_rd));
            chk("rnd_we",     32'(out_we0),   32'(m_we));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
